// File: rtl/tt_um_chiplet_jtag.sv
// tt_um_chiplet_jtag: JTAG TAP (IEEE 1149.1 style) clocked by the system clock.
// TCK/TMS/TDI/TRST_n are synchronised and edge-detected inside the block.
//
// Ports:
//   clk      system clock, all state changes on its rising edge
//   rst_n    asynchronous active-low reset
//   ena      tile select (ignored)
//   ui_in    [0] TCK, [1] TMS, [2] TDI, [3] TRST_n, [7:4] general inputs (SAMPLE)
//   uo_out   [0] TDO, [1] TDO_EN, [5:2] TAP state code, [7:6] zero
//   uio_in   unused
//   uio_out  USER register contents
//   uio_oe   all ones, the bidirectional pins are always driven
module tt_um_chiplet_jtag #(
  parameter logic [31:0] IDCODE = 32'h4A3B1C1D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [3:0] {
    StTlr     = 4'hF,
    StRti     = 4'hC,
    StSelDr   = 4'h7,
    StCapDr   = 4'h6,
    StShDr    = 4'h2,
    StEx1Dr   = 4'h1,
    StPauseDr = 4'h3,
    StEx2Dr   = 4'h0,
    StUpdDr   = 4'h5,
    StSelIr   = 4'h4,
    StCapIr   = 4'hE,
    StShIr    = 4'hA,
    StEx1Ir   = 4'h9,
    StPauseIr = 4'hB,
    StEx2Ir   = 4'h8,
    StUpdIr   = 4'hD
  } tap_state_e;

  localparam logic [3:0] IrIdcode = 4'b0001;
  localparam logic [3:0] IrUser   = 4'b0010;
  localparam logic [3:0] IrSample = 4'b0011;

  // Synchroniser reset value: TCK low, TRST_n high, TMS/TDI low.
  localparam logic [3:0] SyncRst = 4'b1000;

  logic [3:0]  sync1_q, sync2_q;
  logic        tck_prev_q;
  logic        tck_s, tms_s, tdi_s, trst_n_s;
  logic        tck_rise, tck_fall;

  tap_state_e  state_q, state_d;
  logic [3:0]  ir_q;
  logic [3:0]  ir_sr_q;
  logic [31:0] dr_sr_q;
  logic [7:0]  user_q;
  logic        tdo_q, tdo_en_q;

  logic        unused_inputs;
  assign unused_inputs = ^{ena, uio_in};

  assign tck_s    = sync2_q[0];
  assign tms_s    = sync2_q[1];
  assign tdi_s    = sync2_q[2];
  assign trst_n_s = sync2_q[3];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= SyncRst;
      sync2_q    <= SyncRst;
      tck_prev_q <= 1'b0;
    end else begin
      sync1_q    <= ui_in[3:0];
      sync2_q    <= sync1_q;
      tck_prev_q <= sync2_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StTlr:     state_d = tms_s ? StTlr     : StRti;
      StRti:     state_d = tms_s ? StSelDr   : StRti;
      StSelDr:   state_d = tms_s ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms_s ? StEx1Dr   : StShDr;
      StShDr:    state_d = tms_s ? StEx1Dr   : StShDr;
      StEx1Dr:   state_d = tms_s ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms_s ? StEx2Dr   : StPauseDr;
      StEx2Dr:   state_d = tms_s ? StUpdDr   : StShDr;
      StUpdDr:   state_d = tms_s ? StSelDr   : StRti;
      StSelIr:   state_d = tms_s ? StTlr     : StCapIr;
      StCapIr:   state_d = tms_s ? StEx1Ir   : StShIr;
      StShIr:    state_d = tms_s ? StEx1Ir   : StShIr;
      StEx1Ir:   state_d = tms_s ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms_s ? StEx2Ir   : StPauseIr;
      StEx2Ir:   state_d = tms_s ? StUpdIr   : StShIr;
      StUpdIr:   state_d = tms_s ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StTlr;
      ir_q     <= IrIdcode;
      ir_sr_q  <= 4'h0;
      dr_sr_q  <= 32'h0;
      user_q   <= 8'h00;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else if (!trst_n_s) begin
      // TRST drops any partial shift but leaves USER alone.
      state_q  <= StTlr;
      ir_q     <= IrIdcode;
      ir_sr_q  <= 4'h0;
      dr_sr_q  <= 32'h0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      if (tck_rise) begin
        state_q <= state_d;
        // Capture/shift act on the state held before this transition.
        case (state_q)
          StCapIr: ir_sr_q <= 4'b0101;
          StShIr:  ir_sr_q <= {tdi_s, ir_sr_q[3:1]};
          StCapDr: begin
            case (ir_q)
              IrIdcode: dr_sr_q <= IDCODE;
              IrUser:   dr_sr_q <= {24'h0, user_q};
              IrSample: dr_sr_q <= {24'h0, ui_in};
              default:  dr_sr_q <= 32'h0;
            endcase
          end
          StShDr: begin
            // TDI enters at the MSB of the selected register's length.
            case (ir_q)
              IrIdcode:         dr_sr_q <= {tdi_s, dr_sr_q[31:1]};
              IrUser, IrSample: dr_sr_q <= {24'h0, tdi_s, dr_sr_q[7:1]};
              default:          dr_sr_q <= {31'h0, tdi_s};
            endcase
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        tdo_en_q <= (state_q == StShDr) || (state_q == StShIr);
        if (state_q == StShDr)      tdo_q <= dr_sr_q[0];
        else if (state_q == StShIr) tdo_q <= ir_sr_q[0];
        else                        tdo_q <= 1'b0;
        if (state_q == StUpdIr) ir_q <= ir_sr_q;
        if ((state_q == StUpdDr) && (ir_q == IrUser)) user_q <= dr_sr_q[7:0];
      end
      if (state_q == StTlr) ir_q <= IrIdcode;
    end
  end

  assign uo_out  = {2'b00, state_q, tdo_en_q, tdo_q};
  assign uio_out = user_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_chiplet_jtag.sv
module tb_tt_um_chiplet_jtag;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [3:0] ui_hi;
  logic       trst_pin;
  logic [31:0] dout;

  tt_um_chiplet_jtag dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One TCK period; tdo is TDO as seen just before the rising edge.
  task automatic tck(input logic tms, input logic tdi, output logic tdo);
    tdo = uo_out[0];
    ui_in = {ui_hi, trst_pin, tdi, tms, 1'b1};
    wait_clk(6);
    ui_in[0] = 1'b0;
    wait_clk(6);
  endtask

  task automatic step(input logic tms);
    logic d;
    tck(tms, 1'b0, d);
  endtask

  // Shift n bits LSB first, TMS high on the last bit.
  task automatic shift(input int n, input logic [31:0] din, output logic [31:0] dout_o);
    logic b;
    dout_o = 32'h0;
    for (int i = 0; i < n; i++) begin
      tck((i == n - 1), din[i], b);
      dout_o[i] = b;
    end
  endtask

  // From RTI: to Shift-DR / Shift-IR.
  task automatic go_shift_dr();
    step(1'b1); step(1'b0); step(1'b0);
  endtask

  task automatic go_shift_ir();
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
  endtask

  // From Exit1: through Update back to RTI.
  task automatic update_to_rti();
    step(1'b1); step(1'b0);
  endtask

  task automatic load_ir(input logic [3:0] ir, input string tag);
    go_shift_ir();
    shift(4, {28'h0, ir}, dout);
    check(tag, dout, 32'h5);
    update_to_rti();
  endtask

  initial begin
    ena      = 1'b1;
    uio_in   = 8'h00;
    ui_hi    = 4'h0;
    trst_pin = 1'b1;
    ui_in    = 8'h08;
    rst_n    = 1'b0;
    wait_clk(3);
    check("reset_uo_out", {24'h0, uo_out}, 32'h3C);
    check("reset_uio_out", {24'h0, uio_out}, 32'h00);
    check("reset_uio_oe", {24'h0, uio_oe}, 32'hFF);
    rst_n = 1'b1;
    wait_clk(6);
    check("idle_uo_out", {24'h0, uo_out}, 32'h3C);

    // IDCODE read
    step(1'b0);
    check("state_rti", {28'h0, uo_out[5:2]}, 32'hC);
    go_shift_dr();
    check("state_shdr", {28'h0, uo_out[5:2]}, 32'h2);
    check("tdo_en_shdr", {31'h0, uo_out[1]}, 32'h1);
    shift(32, 32'h0, dout);
    check("idcode_read", dout, 32'h4A3B1C1D);
    check("state_ex1dr", {28'h0, uo_out[5:2]}, 32'h1);
    check("tdo_en_ex1dr", {31'h0, uo_out[1]}, 32'h0);
    update_to_rti();

    // IR capture and BYPASS
    load_ir(4'b1111, "ir_capture_bypass");
    go_shift_dr();
    shift(4, 32'b1101, dout);
    check("bypass_delay", dout, 32'b1010);
    update_to_rti();

    // USER write and readback
    load_ir(4'b0010, "ir_capture_user");
    go_shift_dr();
    shift(8, 32'hA5, dout);
    check("user_first_capture", dout, 32'h00);
    update_to_rti();
    check("user_write_a5", {24'h0, uio_out}, 32'hA5);
    go_shift_dr();
    shift(8, 32'h3C, dout);
    check("user_readback", dout, 32'hA5);
    update_to_rti();
    check("user_write_3c", {24'h0, uio_out}, 32'h3C);

    // SAMPLE: TRST_n=1, TDI=0, TMS=0, TCK=1 at the capture edge
    ui_hi = 4'b1100;
    load_ir(4'b0011, "ir_capture_sample");
    go_shift_dr();
    shift(8, 32'hFF, dout);
    check("sample_capture", dout, 32'hC9);
    update_to_rti();
    check("sample_no_update", {24'h0, uio_out}, 32'h3C);
    ui_hi = 4'h0;

    // TRST mid-shift under USER
    load_ir(4'b0010, "ir_capture_trst");
    go_shift_dr();
    step(1'b0); step(1'b0);
    trst_pin = 1'b0;
    ui_in[3] = 1'b0;
    wait_clk(8);
    check("trst_state", {28'h0, uo_out[5:2]}, 32'hF);
    trst_pin = 1'b1;
    ui_in[3] = 1'b1;
    wait_clk(8);
    check("trst_keeps_user", {24'h0, uio_out}, 32'h3C);
    step(1'b0);
    go_shift_dr();
    shift(32, 32'h0, dout);
    check("trst_ir_idcode", dout, 32'h4A3B1C1D);
    update_to_rti();

    // Five TMS=1 from Pause-IR
    step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0);
    check("state_pauseir", {28'h0, uo_out[5:2]}, 32'hB);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("state_after_4_tms", {28'h0, uo_out[5:2]}, 32'h4);
    step(1'b1);
    check("state_after_5_tms", {28'h0, uo_out[5:2]}, 32'hF);

    // rst_n mid-shift
    step(1'b0);
    go_shift_dr();
    step(1'b0);
    check("pre_rst_uio_out", {24'h0, uio_out}, 32'h3C);
    rst_n = 1'b0;
    #1;
    check("rst_mid_uo_out", {24'h0, uo_out}, 32'h3C);
    check("rst_mid_uio_out", {24'h0, uio_out}, 32'h00);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
